// File: rtl/apb_crc_mc_pkg.sv
// Shared types, register offsets and CRC helper functions for the multi-channel APB CRC block.
package apb_crc_mc_pkg;

  localparam int MAX_CH = 8;
  localparam int CH_W   = 3;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_POLY   = 5'h04;
  localparam logic [4:0] OFF_INIT   = 5'h08;
  localparam logic [4:0] OFF_XOROUT = 5'h0C;
  localparam logic [4:0] OFF_DATA   = 5'h10;
  localparam logic [4:0] OFF_RESULT = 5'h14;
  localparam logic [4:0] OFF_STATUS = 5'h18;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [31:0]     data;
    logic [3:0]      strb;
  } fifo_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BYTE = 1'b1
  } engine_state_t;

  // Reverse the low 'width' bits of val; val must be zero above 'width'.
  function automatic logic [31:0] bitrev(input logic [31:0] val, input int unsigned width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = val[31-i];
    end
    return r >> (32 - width);
  endfunction

  // One byte through the MSB-first shift register, with optional input reflection.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [31:0] poly,
                                                input logic [7:0] data, input logic refin,
                                                input int unsigned width);
    logic [31:0] c;
    logic [31:0] rev;
    logic [31:0] mask;
    logic [31:0] top;
    logic [7:0]  b;
    logic        fb;
    rev  = bitrev({24'd0, data}, 8);
    b    = refin ? rev[7:0] : data;
    mask = 32'hFFFF_FFFF >> (32 - width);
    top  = 32'd1 << (width - 1);
    c    = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = (|(c & top)) ^ b[i];
      c  = ((c << 1) ^ (fb ? poly : 32'd0)) & mask;
    end
    return c;
  endfunction

endpackage

// File: rtl/apb_crc_mc_fifo.sv
// Shared data FIFO of fifo_entry_t; pop data appears on pop_data the cycle after pop.
module apb_crc_mc_fifo
  import apb_crc_mc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  fifo_entry_t            push_data,
  input  logic                   pop,
  output fifo_entry_t            pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign level     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and the registered pop output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      pop_data <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
        pop_data <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/apb_crc_mc.sv
// Multi-channel APB CRC accelerator: per-channel CRC contexts fed from a shared byte-strobed FIFO.
module apb_crc_mc
  import apb_crc_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CRC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] s_paddr,
  input  logic [DATA_WIDTH-1:0] s_pwdata,
  output logic [DATA_WIDTH-1:0] s_prdata,
  output logic                  s_pslverr,
  input  logic                  s_pwrite,
  input  logic                  s_psel,
  input  logic                  s_penable,
  output logic                  s_pready,
  input  logic [3:0]            s_pstrb
);

  localparam logic [31:0] CRC_MASK = 32'hFFFF_FFFF >> (32 - CRC_WIDTH);
  // One entry can sit in the engine on top of a full FIFO.
  localparam int          PW       = $clog2(FIFO_DEPTH + 2);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  logic [31:0]   poly_r     [MAX_CH];
  logic [31:0]   init_r     [MAX_CH];
  logic [31:0]   xorout_r   [MAX_CH];
  logic [31:0]   crc_r      [MAX_CH];
  logic          refin_r    [MAX_CH];
  logic          refout_r   [MAX_CH];
  logic [PW-1:0] pending_r  [MAX_CH];

  logic              access_s, ch_ok_s, off_ok_s, is_cfg_s, err_s, stall_s, done_s, wr_ok_s;
  logic [CH_W-1:0]   ch_idx_s;
  logic [4:0]        off_s;
  logic              push_s, pop_s, fifo_full_s, fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_unused_s;
  logic              addr_unused_s;
  fifo_entry_t       push_entry_s, cur_s;
  engine_state_t     state_r, state_nxt_s;
  logic [3:0]        done_mask_r, remain_s, onehot_s;
  logic [1:0]        byte_idx_s;
  logic              last_byte_s, eng_step_s, eng_done_s;
  logic [7:0]        byte_s;
  logic [31:0]       step_crc_s, result_s, rdata_s;
  logic [7:0]        pend_ext_s;

  assign access_s      = s_psel & s_penable;
  assign ch_idx_s      = s_paddr[7:5];
  assign off_s         = s_paddr[4:0];
  assign addr_unused_s = ^s_paddr[ADDR_WIDTH-1:8];
  assign ch_ok_s       = (int'(ch_idx_s) < NUM_CH);

  // Offset decode: which offsets exist and which are blocked while the channel is busy.
  always_comb begin
    off_ok_s = 1'b0;
    is_cfg_s = 1'b0;
    case (off_s)
      OFF_CTRL, OFF_POLY, OFF_INIT, OFF_XOROUT, OFF_RESULT: begin
        off_ok_s = 1'b1;
        is_cfg_s = 1'b1;
      end
      OFF_DATA, OFF_STATUS: begin
        off_ok_s = 1'b1;
        is_cfg_s = 1'b0;
      end
      default: begin
        off_ok_s = 1'b0;
        is_cfg_s = 1'b0;
      end
    endcase
  end

  assign err_s   = ~ch_ok_s | ~off_ok_s | (s_pwrite & ((off_s == OFF_RESULT) | (off_s == OFF_STATUS)));
  assign stall_s = ~err_s & ((is_cfg_s & (pending_r[ch_idx_s] != {PW{1'b0}})) |
                             (s_pwrite & (off_s == OFF_DATA) & (s_pstrb != 4'd0) & fifo_full_s));
  assign done_s  = access_s & ~stall_s;
  assign wr_ok_s = done_s & s_pwrite & ~err_s;
  assign push_s  = wr_ok_s & (off_s == OFF_DATA) & (s_pstrb != 4'd0);

  assign push_entry_s = '{ch: ch_idx_s, data: s_pwdata[31:0], strb: s_pstrb};

  apb_crc_mc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (cur_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_unused_s)
  );

  // Pick the lowest strobed byte not yet consumed from the current entry.
  always_comb begin
    remain_s = cur_s.strb & ~done_mask_r;
    casez (remain_s)
      4'b???1: byte_idx_s = 2'd0;
      4'b??10: byte_idx_s = 2'd1;
      4'b?100: byte_idx_s = 2'd2;
      4'b1000: byte_idx_s = 2'd3;
      default: byte_idx_s = 2'd0;
    endcase
    onehot_s    = 4'b0001 << byte_idx_s;
    last_byte_s = ((remain_s & ~onehot_s) == 4'd0);
  end

  // Engine next state; the entry stays on cur_s until the next pop, so BYTE reads it directly.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = BYTE;
        end else begin
          pop_s       = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      BYTE: begin
        if (last_byte_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BYTE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign eng_step_s = (state_r == BYTE);
  assign eng_done_s = eng_step_s & last_byte_s;
  assign byte_s     = cur_s.data[{byte_idx_s, 3'b000} +: 8];
  assign step_crc_s = crc_byte_step(crc_r[cur_s.ch], poly_r[cur_s.ch], byte_s,
                                    refin_r[cur_s.ch], CRC_WIDTH);

  // Engine state and the set of bytes already consumed from the current entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      done_mask_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (eng_step_s && !last_byte_s) begin
        done_mask_r <= done_mask_r | onehot_s;
      end else begin
        done_mask_r <= 4'd0;
      end
    end
  end

  // Per-channel configuration, CRC state and pending counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < MAX_CH; c++) begin
        poly_r[c]    <= 32'd0;
        init_r[c]    <= 32'd0;
        xorout_r[c]  <= 32'd0;
        crc_r[c]     <= 32'd0;
        refin_r[c]   <= 1'b0;
        refout_r[c]  <= 1'b0;
        pending_r[c] <= {PW{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok_s && (int'(ch_idx_s) == c)) begin
          case (off_s)
            OFF_CTRL: begin
              refin_r[c]  <= s_pwdata[1];
              refout_r[c] <= s_pwdata[2];
              if (s_pwdata[0]) begin
                crc_r[c] <= init_r[c];
              end
            end
            OFF_POLY:   poly_r[c]   <= s_pwdata[31:0] & CRC_MASK;
            OFF_INIT:   init_r[c]   <= s_pwdata[31:0] & CRC_MASK;
            OFF_XOROUT: xorout_r[c] <= s_pwdata[31:0] & CRC_MASK;
            default: ;
          endcase
        end
        if (eng_step_s && (int'(cur_s.ch) == c)) begin
          crc_r[c] <= step_crc_s;
        end
        case ({push_s && (int'(ch_idx_s) == c), eng_done_s && (int'(cur_s.ch) == c)})
          2'b10:   pending_r[c] <= pending_r[c] + PEND_ONE;
          2'b01:   pending_r[c] <= pending_r[c] - PEND_ONE;
          default: pending_r[c] <= pending_r[c];
        endcase
      end
    end
  end

  assign result_s   = ((refout_r[ch_idx_s] ? bitrev(crc_r[ch_idx_s], CRC_WIDTH) : crc_r[ch_idx_s])
                       ^ xorout_r[ch_idx_s]) & CRC_MASK;
  assign pend_ext_s = 8'(pending_r[ch_idx_s]);

  // Read mux; data is only driven for a completing, error-free read.
  always_comb begin
    rdata_s = 32'd0;
    if (done_s && !err_s && !s_pwrite) begin
      case (off_s)
        OFF_CTRL:   rdata_s = {29'd0, refout_r[ch_idx_s], refin_r[ch_idx_s], 1'b0};
        OFF_POLY:   rdata_s = poly_r[ch_idx_s];
        OFF_INIT:   rdata_s = init_r[ch_idx_s];
        OFF_XOROUT: rdata_s = xorout_r[ch_idx_s];
        OFF_RESULT: rdata_s = result_s;
        OFF_STATUS: rdata_s = {24'd0, pend_ext_s[3:0], 3'd0, (pending_r[ch_idx_s] != {PW{1'b0}})};
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign s_prdata  = DATA_WIDTH'(rdata_s);
  assign s_pready  = done_s;
  assign s_pslverr = done_s & err_s;

endmodule

// File: tb/tb_apb_crc_mc.sv
// Self-checking bench for apb_crc_mc: directed CRC-32 vectors plus randomized traffic against a reference model.
module tb_apb_crc_mc;

  localparam int W = 32;
  localparam logic [31:0] M = 32'hFFFF_FFFF >> (32 - W);

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] paddr, pwdata, prdata;
  logic        pslverr, pwrite, psel, penable, pready;
  logic [3:0]  pstrb;

  always #5 clk = ~clk;

  apb_crc_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CH(4), .CRC_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .s_paddr(paddr), .s_pwdata(pwdata), .s_prdata(prdata),
    .s_pslverr(pslverr), .s_pwrite(pwrite), .s_psel(psel), .s_penable(penable),
    .s_pready(pready), .s_pstrb(pstrb)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] r_data;
  logic        r_err;
  int          r_waits;

  logic [31:0] m_poly [4], m_init [4], m_xor [4], m_crc [4];
  logic        m_refin [4], m_refout [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup cycle, then access until pready, bounded.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    r_waits = 0;
    @(negedge clk);
    while (!pready && r_waits < 300) begin
      r_waits++;
      @(negedge clk);
    end
    check("pready_timeout", {31'd0, pready}, 32'd1);
    r_data = prdata;
    r_err  = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  function automatic logic [31:0] rev(input logic [31:0] x, input int w);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < w; i++) r = (r << 1) | ((x >> i) & 32'd1);
    return r;
  endfunction

  // Reference: reflected-input channels run the LSB-first algorithm on a reflected register.
  function automatic logic [31:0] m_step(input logic [31:0] crc, input logic [31:0] poly,
                                         input logic refin, input logic [7:0] b);
    logic [31:0] r;
    if (refin) begin
      r = rev(crc, W) ^ {24'd0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ rev(poly, W)) : (r >> 1);
      return rev(r, W);
    end else begin
      r = crc ^ ({24'd0, b} << (W - 8));
      for (int k = 0; k < 8; k++) r = ((r >> (W - 1)) & 32'd1) != 0 ? (((r << 1) ^ poly) & M) : ((r << 1) & M);
      return r;
    end
  endfunction

  function automatic logic [31:0] m_result(input int ch);
    return ((m_refout[ch] ? rev(m_crc[ch], W) : m_crc[ch]) ^ m_xor[ch]) & M;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_poly[c] = 32'd0; m_init[c] = 32'd0; m_xor[c] = 32'd0; m_crc[c] = 32'd0;
      m_refin[c] = 1'b0; m_refout[c] = 1'b0;
    end
  endtask

  task automatic cfg(input int ch, input logic [31:0] poly, input logic [31:0] init,
                     input logic [31:0] xorv, input logic [2:0] ctrl);
    logic [31:0] base;
    base = 32'(ch) * 32'h20;
    apb(1'b1, base + 32'h04, poly, 4'hF);  m_poly[ch] = poly & M;
    apb(1'b1, base + 32'h08, init, 4'hF);  m_init[ch] = init & M;
    apb(1'b1, base + 32'h0C, xorv, 4'hF);  m_xor[ch]  = xorv & M;
    apb(1'b1, base, {29'd0, ctrl}, 4'hF);
    m_refin[ch] = ctrl[1]; m_refout[ch] = ctrl[2];
    if (ctrl[0]) m_crc[ch] = m_init[ch];
  endtask

  task automatic dwr(input int ch, input logic [31:0] data, input logic [3:0] strb);
    logic [7:0] b;
    apb(1'b1, 32'(ch) * 32'h20 + 32'h10, data, strb);
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        b = data[8*k +: 8];
        m_crc[ch] = m_step(m_crc[ch], m_poly[ch], m_refin[ch], b);
      end
    end
  endtask

  task automatic rd(input int ch, input logic [4:0] off);
    apb(1'b0, 32'(ch) * 32'h20 + {27'd0, off}, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0; pstrb = 4'h0;
    rstn = 1'b0;
    #23;
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    m_reset();
  endtask

  task automatic scenario_crc32();
    cfg(0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7);
    dwr(0, 32'h34333231, 4'hF);
    dwr(0, 32'h38373635, 4'hF);
    dwr(0, 32'h00000039, 4'h1);
    rd(0, 5'h14);
    check("crc32_result", r_data, 32'hCBF43926);
  endtask

  logic [31:0] offs [7];
  int          max_waits;

  initial begin
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    do_reset();

    // Reset values across the whole map.
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 7; o++) begin
        apb(1'b0, 32'(c) * 32'h20 + offs[o], 32'd0, 4'h0);
        check("reset_read", r_data, 32'd0);
        check("reset_err", {31'd0, r_err}, 32'd0);
      end
    end

    scenario_crc32();

    // ch0 CRC-32 and ch1 CRC-32/MPEG-2 interleaved word by word.
    cfg(0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7);
    cfg(1, 32'h04C11DB7, 32'hFFFFFFFF, 32'h00000000, 3'd1);
    dwr(0, 32'h34333231, 4'hF); dwr(1, 32'h34333231, 4'hF);
    dwr(0, 32'h38373635, 4'hF); dwr(1, 32'h38373635, 4'hF);
    dwr(0, 32'h00000039, 4'h1); dwr(1, 32'h00000039, 4'h1);
    rd(1, 5'h14); check("mpeg2_result", r_data, 32'h0376E6E7);
    rd(0, 5'h14); check("crc32_interleaved", r_data, 32'hCBF43926);
    rd(1, 5'h00); check("ctrl_readback", r_data, 32'd0);

    // Back-to-back DATA writes overrun the FIFO; RESULT then waits for the channel to drain.
    cfg(2, $urandom, $urandom, $urandom, {$urandom_range(0, 3) == 0 ? 2'b00 : 2'(($urandom_range(0, 3))), 1'b1});
    max_waits = 0;
    for (int k = 0; k < 8; k++) begin
      dwr(2, $urandom, 4'hF);
      if (k == 0) check("first_write_nostall", 32'(r_waits), 32'd0);
      if (r_waits > max_waits) max_waits = r_waits;
    end
    check("fifo_full_stall_seen", {31'd0, max_waits > 0}, 32'd1);
    rd(2, 5'h18);
    check("status_nostall", 32'(r_waits), 32'd0);
    check("status_busy", {31'd0, (r_data[0] == 1'b1) && (r_data[7:4] != 4'd0)}, 32'd1);
    rd(2, 5'h14);
    check("result_stalled", {31'd0, r_waits > 0}, 32'd1);
    check("result_after_stall", r_data, m_result(2));
    rd(2, 5'h18);
    check("status_idle", r_data, 32'd0);

    // Error responses leave state untouched.
    rd(4, 5'h00);
    check("ch4_err", {31'd0, r_err}, 32'd1);
    check("ch4_rdata", r_data, 32'd0);
    apb(1'b1, 32'h84, 32'h12345678, 4'hF);
    check("ch4_wr_err", {31'd0, r_err}, 32'd1);
    apb(1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
    check("result_wr_err", {31'd0, r_err}, 32'd1);
    apb(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF);
    check("status_wr_err", {31'd0, r_err}, 32'd1);
    rd(0, 5'h1C);
    check("unused_off_err", {31'd0, r_err}, 32'd1);
    rd(0, 5'h14);
    check("result_unchanged", r_data, 32'hCBF43926);
    dwr(0, 32'hA5A5A5A5, 4'h0);
    check("strb0_err", {31'd0, r_err}, 32'd0);
    rd(0, 5'h18);
    check("strb0_status", r_data, 32'd0);
    rd(0, 5'h14);
    check("strb0_result", r_data, 32'hCBF43926);

    // Randomized configurations and interleaved traffic.
    for (int round = 0; round < 4; round++) begin
      for (int c = 0; c < 4; c++) begin
        cfg(c, $urandom, $urandom, $urandom, {1'($urandom), 1'($urandom), 1'b1});
      end
      for (int k = 0; k < 14; k++) begin
        dwr($urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)));
      end
      for (int c = 0; c < 4; c++) begin
        rd(c, 5'h14);
        check("random_result", r_data, m_result(c));
        rd(c, 5'h04);
        check("random_poly", r_data, m_poly[c]);
      end
    end

    // Reset while entries are in flight.
    cfg(0, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7);
    dwr(0, $urandom, 4'hF);
    dwr(0, $urandom, 4'hF);
    dwr(0, $urandom, 4'hF);
    do_reset();
    rd(0, 5'h18); check("midrst_status", r_data, 32'd0);
    rd(0, 5'h04); check("midrst_poly", r_data, 32'd0);
    rd(0, 5'h0C); check("midrst_xorout", r_data, 32'd0);
    rd(0, 5'h14); check("midrst_result", r_data, 32'd0);
    rd(0, 5'h00); check("midrst_ctrl", r_data, 32'd0);
    scenario_crc32();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
